stopwatch_lap_controller: RTL

- Sequences the stopwatch counter from debounced button edges: start/stop, lap capture, clear, and lap review.
- Holds a small lap-time buffer and selects what reaches the seven-segment display: the live time, a frozen lap, or a reviewed lap.
- Sits between the button debouncers and the counter/display.
- Drives the counter run enable and a clear pulse.

---
 rtl/stopwatch_lap_controller_if.sv | 32 +++
 rtl/stopwatch_lap_controller.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/stopwatch_lap_controller_if.sv
// Signal bundle between the button/counter side (master) and the stopwatch lap controller (slave).
`timescale 1ns/1ps
interface stopwatch_lap_controller_if #(
   parameter int AW = 3
);
   logic          tick_1ms;
   logic          start_edge;
   logic          lap_edge;
   logic          review_edge;
   logic [6:0]    live_cs;
   logic [5:0]    live_sec;
   logic [5:0]    live_min;
   logic          run_en;
   logic          clear;
   logic [6:0]    disp_cs;
   logic [5:0]    disp_sec;
   logic [5:0]    disp_min;
   logic          disp_is_lap;
   logic [AW-1:0] lap_idx;
   logic [AW:0]   lap_count;
   logic          lap_full;

   modport master (
      output tick_1ms, start_edge, lap_edge, review_edge, live_cs, live_sec, live_min,
      input  run_en, clear, disp_cs, disp_sec, disp_min, disp_is_lap, lap_idx, lap_count, lap_full
   );

   modport slave (
      input  tick_1ms, start_edge, lap_edge, review_edge, live_cs, live_sec, live_min,
      output run_en, clear, disp_cs, disp_sec, disp_min, disp_is_lap, lap_idx, lap_count, lap_full
   );
endinterface

// File: rtl/stopwatch_lap_controller.sv
// Stopwatch sequencer: start/stop, lap capture with timed display hold, clear and lap review.
`timescale 1ns/1ps
module stopwatch_lap_controller #(
   parameter int LAP_DEPTH = 8,
   parameter int AW        = 3,
   parameter int HOLD_MS   = 3000
) (
   input logic                  clk,
   input logic                  rst,
   stopwatch_lap_controller_if.slave bus
);

   typedef enum logic [2:0] {IDLE, RUNNING, LAP_HOLD, PAUSED, REVIEW} state_t;

   typedef struct packed {
      logic [5:0] min;
      logic [5:0] sec;
      logic [6:0] cs;
   } lap_t;

   localparam int            HW         = $clog2(HOLD_MS + 1);
   localparam logic [HW-1:0] HOLD_LOAD  = HW'(HOLD_MS);
   localparam logic [HW-1:0] HOLD_ONE   = HW'(1);
   localparam logic [AW-1:0] IDX_ONE    = AW'(1);
   localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);
   localparam logic [AW:0]   CNT_DEPTH  = (AW+1)'(LAP_DEPTH);

   state_t        state, state_nxt;
   logic [HW-1:0] hold_cnt, hold_nxt;
   logic [AW:0]   count_nxt;
   logic [AW-1:0] idx_nxt;
   logic          capture;

   lap_t          lap_buf [LAP_DEPTH];
   lap_t          live, disp_nxt;
   logic          run_nxt, clear_nxt, is_lap_nxt, full_nxt;
   logic          st, lp, rv;

   assign live = {bus.live_min, bus.live_sec, bus.live_cs};

   // Coincident edges resolve start > lap > review; losers are dropped.
   assign st = bus.start_edge;
   assign lp = bus.lap_edge & ~bus.start_edge;
   assign rv = bus.review_edge & ~bus.start_edge & ~bus.lap_edge;

   // NOTE: every variable assigned in an always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      hold_nxt  = hold_cnt;
      count_nxt = bus.lap_count;
      idx_nxt   = '0;
      capture   = 1'b0;
      unique case (state)
         IDLE: begin
            if (st) state_nxt = RUNNING;
         end
         RUNNING: begin
            if (st)                         state_nxt = PAUSED;
            else if (lp && !bus.lap_full)   capture   = 1'b1;
         end
         LAP_HOLD: begin
            if (st)                         state_nxt = PAUSED;
            else if (lp && !bus.lap_full)   capture   = 1'b1;
            else if (bus.tick_1ms) begin
               if (hold_cnt <= HOLD_ONE) begin
                  hold_nxt  = '0;
                  state_nxt = RUNNING;
               end else begin
                  hold_nxt  = hold_cnt - HOLD_ONE;
               end
            end
         end
         PAUSED: begin
            if (st) state_nxt = RUNNING;
            else if (lp) begin
               count_nxt = '0;
               state_nxt = IDLE;
            end else if (rv && (bus.lap_count != '0)) begin
               state_nxt = REVIEW;
            end
         end
         REVIEW: begin
            idx_nxt = bus.lap_idx;
            if (st)      state_nxt = RUNNING;
            else if (lp) state_nxt = PAUSED;
            else if (rv) idx_nxt = ({1'b0, bus.lap_idx} == (bus.lap_count - CNT_ONE)) ? '0
                                                                                     : bus.lap_idx + IDX_ONE;
         end
         default: state_nxt = IDLE;
      endcase

      // A capture reloads the hold even when a tick lands in the same cycle.
      if (capture) begin
         state_nxt = LAP_HOLD;
         hold_nxt  = HOLD_LOAD;
         count_nxt = bus.lap_count + CNT_ONE;
      end
      if (state_nxt == LAP_HOLD) idx_nxt = count_nxt[AW-1:0] - IDX_ONE;
   end

   always_comb begin
      disp_nxt   = live;
      is_lap_nxt = (state_nxt == LAP_HOLD) || (state_nxt == REVIEW);
      // The capture cycle bypasses the buffer so the new lap shows immediately.
      if (is_lap_nxt && !capture) disp_nxt = lap_buf[idx_nxt];
      run_nxt    = (state_nxt == RUNNING) || (state_nxt == LAP_HOLD);
      clear_nxt  = lp && ((state == IDLE) || (state == PAUSED));
      full_nxt   = (count_nxt == CNT_DEPTH);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         hold_cnt        <= '0;
         bus.run_en      <= 1'b0;
         bus.clear       <= 1'b0;
         bus.disp_cs     <= '0;
         bus.disp_sec    <= '0;
         bus.disp_min    <= '0;
         bus.disp_is_lap <= 1'b0;
         bus.lap_idx     <= '0;
         bus.lap_count   <= '0;
         bus.lap_full    <= 1'b0;
      end else begin
         state           <= state_nxt;
         hold_cnt        <= hold_nxt;
         bus.run_en      <= run_nxt;
         bus.clear       <= clear_nxt;
         bus.disp_cs     <= disp_nxt.cs;
         bus.disp_sec    <= disp_nxt.sec;
         bus.disp_min    <= disp_nxt.min;
         bus.disp_is_lap <= is_lap_nxt;
         bus.lap_idx     <= idx_nxt;
         bus.lap_count   <= count_nxt;
         bus.lap_full    <= full_nxt;
      end
   end

   // NOTE: the lap buffer has no reset; entries are only meaningful below lap_count.
   always_ff @(posedge clk) begin
      if (capture) lap_buf[bus.lap_count[AW-1:0]] <= live;
   end

endmodule
